// File: rtl/avl_button_pio.sv
// Push-button responder: sync, debounce, press capture and irq.
// Avalon-MM slave with fixed read latency of one clock.
module avl_button_pio #(
  parameter int WIDTH           = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] button_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE =
    {WIDTH{ACTIVE_LOW != 0}};

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_db_d;
  logic [WIDTH-1:0] r_ec;
  logic [WIDTH-1:0] r_mask;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic             r_irq;
  logic [31:0]      r_rdata;
  logic             r_rvalid;

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr_mask;
  logic             w_wr_ec;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_raw     = r_sync2 ^ IDLE;
  assign w_rise    = r_db & ~r_db_d;
  assign w_wr_mask = avs_write &&
                     (avs_address == 2'd2);
  assign w_wr_ec   = avs_write &&
                     (avs_address == 2'd3);
  assign w_clr     = w_wr_ec ?
                     avs_writedata[WIDTH-1:0] :
                     '0;
  assign w_unused  = ^avs_writedata;

  // Sync flops reset to the idle pin level so
  // no spurious press follows reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync1 <= IDLE;
      r_sync2 <= IDLE;
    end else begin
      r_sync1 <= button_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < WIDTH; i++)
        r_cnt[i] <= '0;
      r_db <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_raw[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CMAX) begin
          r_cnt[i] <= '0;
          r_db[i]  <= ~r_db[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Set beats clear when both hit one bit.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_db_d <= '0;
      r_ec   <= '0;
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_db_d <= r_db;
      r_ec   <= (r_ec & ~w_clr) | w_rise;
      if (w_wr_mask)
        r_mask <= avs_writedata[WIDTH-1:0];
      r_irq  <= |(r_ec & r_mask);
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (avs_address)
      2'd0: w_rd[WIDTH-1:0] = r_db;
      2'd1: w_rd[WIDTH-1:0] = w_raw;
      2'd2: w_rd[WIDTH-1:0] = r_mask;
      2'd3: w_rd[WIDTH-1:0] = r_ec;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= avs_read;
      if (avs_read)
        r_rdata <= w_rd;
    end
  end

  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rvalid;
  assign irq               = r_irq;

endmodule

// File: tb/tb_avl_button_pio.sv
// Directed bench for avl_button_pio.
// WIDTH=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4.
module tb_avl_button_pio;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [1:0]  button_in;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq;

  int total = 0;
  int bad   = 0;

  avl_button_pio #(
    .WIDTH(2),
    .ACTIVE_LOW(1),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .button_in(button_in),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [1:0] a,
                    input logic [31:0] exp);
    avs_address = a;
    avs_read    = 1'b1;
    tick(1);
    avs_read = 1'b0;
    chk({tag, "_v"}, {31'd0, avs_readdatavalid}, 1);
    chk(tag, avs_readdata, exp);
    tick(1);
    chk({tag, "_v0"}, {31'd0, avs_readdatavalid}, 0);
    chk({tag, "_hold"}, avs_readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick(1);
    avs_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] burst [4];
    reset_reset   = 1'b1;
    button_in     = 2'b11;
    avs_address   = 2'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    tick(3);
    chk("rst_rdata", avs_readdata, 0);
    chk("rst_rvalid", {31'd0, avs_readdatavalid}, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    reset_reset = 1'b0;
    rd("r0_init", 2'd0, 0);
    rd("r3_init", 2'd3, 0);

    // 3-clock glitch must be rejected
    button_in = 2'b10;
    tick(3);
    button_in = 2'b11;
    tick(8);
    rd("glitch_r0", 2'd0, 0);
    rd("glitch_r3", 2'd3, 0);

    // held press: state visible 6 edges on
    button_in   = 2'b10;
    avs_address = 2'd0;
    avs_read    = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick(1);
      chk($sformatf("lat%0d", k), avs_readdata,
          (k == 6) ? 32'd1 : 32'd0);
    end
    avs_address = 2'd3;
    tick(1);
    avs_read = 1'b0;
    chk("lat_r3", avs_readdata, 1);
    wr(2'd3, 32'd1);
    rd("clr_r3", 2'd3, 0);
    rd("held_r0", 2'd0, 1);
    button_in = 2'b11;
    tick(10);
    rd("rel_r0", 2'd0, 0);
    rd("rel_r3", 2'd3, 0);

    // interrupt path
    wr(2'd2, 32'd1);
    rd("mask_r2", 2'd2, 1);
    chk("irq_idle", {31'd0, irq}, 0);
    button_in = 2'b10;
    tick(7);
    chk("irq_pre", {31'd0, irq}, 0);
    tick(1);
    chk("irq_set", {31'd0, irq}, 1);
    wr(2'd3, 32'd1);
    chk("irq_lag", {31'd0, irq}, 1);
    tick(1);
    chk("irq_clr", {31'd0, irq}, 0);
    rd("irq_r3", 2'd3, 0);
    button_in = 2'b11;
    tick(10);
    button_in = 2'b01;
    tick(10);
    rd("b1_r3", 2'd3, 2);
    chk("b1_irq", {31'd0, irq}, 0);
    wr(2'd3, 32'd2);
    button_in = 2'b11;
    tick(10);
    rd("b1_clr", 2'd3, 0);

    // clear in the press-event cycle
    button_in = 2'b10;
    tick(6);
    wr(2'd3, 32'd1);
    rd("race_r3", 2'd3, 1);

    // back-to-back reads
    wr(2'd2, 32'd2);
    button_in = 2'b00;
    tick(2);
    burst[0] = 32'd1;
    burst[1] = 32'd3;
    burst[2] = 32'd2;
    burst[3] = 32'd1;
    avs_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      avs_address = 2'(k);
      tick(1);
      chk($sformatf("b2b%0d_v", k),
          {31'd0, avs_readdatavalid}, 1);
      chk($sformatf("b2b%0d", k),
          avs_readdata, burst[k]);
    end
    avs_read = 1'b0;
    tick(1);
    chk("b2b_end", {31'd0, avs_readdatavalid}, 0);
    wr(2'd0, 32'hFFFF_FFFF);
    rd("ro_r0", 2'd0, 3);
    chk("b1_irq_on", {31'd0, irq}, 1);

    // reset while button 0 held
    button_in = 2'b10;
    tick(10);
    reset_reset = 1'b1;
    avs_address = 2'd0;
    avs_read    = 1'b1;
    tick(1);
    reset_reset = 1'b0;
    chk("mrst_rvalid", {31'd0, avs_readdatavalid}, 0);
    chk("mrst_rdata", avs_readdata, 0);
    chk("mrst_irq", {31'd0, irq}, 0);
    avs_address = 2'd3;
    tick(1);
    chk("mrst_r3_v", {31'd0, avs_readdatavalid}, 1);
    chk("mrst_r3", avs_readdata, 0);
    avs_address = 2'd2;
    tick(1);
    chk("mrst_r2", avs_readdata, 0);
    avs_address = 2'd0;
    for (int k = 3; k <= 7; k++) begin
      tick(1);
      chk($sformatf("redet%0d", k), avs_readdata,
          (k == 7) ? 32'd1 : 32'd0);
    end
    avs_address = 2'd3;
    tick(1);
    avs_read = 1'b0;
    chk("redet_r3", avs_readdata, 1);
    tick(1);
    chk("redet_irq", {31'd0, irq}, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
